// File: rtl/i2c_reg_target.sv
// i2c_reg_target: write-only I2C target with a 16 x 9-bit register file.
//
// Each write frame is START, address byte (DEV_ADDR + W), byte1, byte2.
// - byte1 carries reg_addr[6:0] in bits 7:1 and data bit 8 in bit 0.
// - byte2 carries data bits 7:0.
// The target ACKs all three bytes, reports the write on the wr_* outputs,
// and NACKs any further bytes until STOP or START. A write to register
// 0x0F clears the whole register file.
//
// Ports:
//   i_clk, i_rst_n  system clock, asynchronous active-low reset
//   i_scl, i_sda    asynchronous I2C bus inputs, synchronized internally
//   o_sda_oen       1 = pull SDA low (ACK)
//   o_wr_valid      one-cycle pulse per accepted write
//   o_wr_addr       register address of the last accepted write
//   o_wr_data       data of the last accepted write
//   i_rd_addr       register-file read index
//   o_rd_data       combinational read data for i_rd_addr
//   o_busy          high between START and STOP
//   o_nack          one-cycle pulse for each declined byte
module i2c_reg_target #(
  parameter logic [6:0] DEV_ADDR    = 7'h1A,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_scl,
  input  logic       i_sda,
  output logic       o_sda_oen,
  output logic       o_wr_valid,
  output logic [6:0] o_wr_addr,
  output logic [8:0] o_wr_data,
  input  logic [3:0] i_rd_addr,
  output logic [8:0] o_rd_data,
  output logic       o_busy,
  output logic       o_nack
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ACK_A, BYTE1, ACK_1, BYTE2, ACK_2, IGNORE
  } state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic       scl, sda, scl_prev, sda_prev;
  logic       scl_rise, scl_fall, start_det, stop_det;
  logic       byte_done, addr_match, commit, decline;
  logic [3:0] bit_cnt;
  logic [7:0] shift;
  logic [6:0] reg_addr;
  logic       d8;
  logic [8:0] regs [16];

  // Synchronizer chains plus one extra history flop for edge detection.
  // Everything resets to 1 (idle bus) so reset release never looks like
  // a START.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_sync[0] <= i_scl;
      sda_sync[0] <= i_sda;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        scl_sync[i] <= scl_sync[i-1];
        sda_sync[i] <= sda_sync[i-1];
      end
      scl_prev <= scl;
      sda_prev <= sda;
    end
  end

  assign scl       = scl_sync[SYNC_STAGES-1];
  assign sda       = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl & ~scl_prev;
  assign scl_fall  = ~scl & scl_prev;
  assign start_det = scl & scl_prev & sda_prev & ~sda;
  assign stop_det  = scl & scl_prev & ~sda_prev & sda;

  // A byte is complete on the SCL fall that follows the 8th sampled bit.
  assign byte_done  = scl_fall && (bit_cnt == 4'd8);
  assign addr_match = (shift[7:1] == DEV_ADDR) && !shift[0];

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state logic. STOP and START override everything; commit and
  // decline are strobes consumed by the datapath in the same cycle.
  always_comb begin
    state_next = state;
    commit     = 1'b0;
    decline    = 1'b0;
    if (stop_det) begin
      state_next = IDLE;
    end else if (start_det) begin
      state_next = ADDR;
    end else begin
      case (state)
        ADDR: if (byte_done) begin
          if (addr_match) begin
            state_next = ACK_A;
          end else begin
            state_next = IGNORE;
            decline    = 1'b1;
          end
        end
        ACK_A:  if (scl_fall)  state_next = BYTE1;
        BYTE1:  if (byte_done) state_next = ACK_1;
        ACK_1:  if (scl_fall)  state_next = BYTE2;
        BYTE2:  if (byte_done) begin
          state_next = ACK_2;
          commit     = 1'b1;
        end
        ACK_2:  if (scl_fall)  state_next = IGNORE;
        IGNORE: if (byte_done) decline = 1'b1;
        default: state_next = IDLE;
      endcase
    end
  end

  // State-decoded outputs; the async reset forces IDLE, which releases SDA
  // without waiting for a clock edge.
  always_comb begin
    o_sda_oen = (state == ACK_A) || (state == ACK_1) || (state == ACK_2);
    o_busy    = (state != IDLE);
  end

  // Bit counter, shift register, byte latches, write strobes and the
  // register file. In IGNORE the counter also walks through the 9th (ACK)
  // clock (value 9) so every declined byte yields exactly one o_nack.
  // An address decline enters IGNORE at 8 because its 9th clock is next.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bit_cnt    <= '0;
      shift      <= '0;
      reg_addr   <= '0;
      d8         <= 1'b0;
      o_nack     <= 1'b0;
      o_wr_valid <= 1'b0;
      o_wr_addr  <= '0;
      o_wr_data  <= '0;
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else begin
      o_nack     <= decline;
      o_wr_valid <= commit;
      if (start_det || stop_det) begin
        bit_cnt <= '0;
      end else begin
        case (state)
          ADDR, BYTE1, BYTE2: begin
            if (scl_rise && bit_cnt < 4'd8) begin
              shift   <= {shift[6:0], sda};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (byte_done) begin
              bit_cnt <= decline ? 4'd8 : 4'd0;
            end
          end
          IGNORE: begin
            if (scl_rise && bit_cnt < 4'd9)       bit_cnt <= bit_cnt + 4'd1;
            else if (scl_fall && bit_cnt == 4'd9) bit_cnt <= '0;
          end
          default: bit_cnt <= '0;
        endcase
      end
      if (state == BYTE1 && state_next == ACK_1) begin
        reg_addr <= shift[7:1];
        d8       <= shift[0];
      end
      if (commit) begin
        o_wr_addr <= reg_addr;
        o_wr_data <= {d8, shift};
        if (reg_addr <= 7'h0E) begin
          regs[reg_addr[3:0]] <= {d8, shift};
        end else if (reg_addr == 7'h0F) begin
          for (int i = 0; i < 16; i++) regs[i] <= '0;
        end
      end
    end
  end

  assign o_rd_data = regs[i_rd_addr];

endmodule

// File: tb/tb_i2c_reg_target.sv
// Self-checking bench for i2c_reg_target. A bit-banged I2C master drives
// the bus; the expected write of each accepted frame goes into a queue and
// a monitor pops and compares it whenever o_wr_valid pulses. A small
// register-file model tracks expected read data.
module tb_i2c_reg_target;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_bus;
  logic [3:0] rd_addr = '0;
  logic       sda_oen, wr_valid, busy, nack;
  logic [6:0] wr_addr;
  logic [8:0] wr_data, rd_data;

  typedef struct packed {
    logic [6:0] addr;
    logic [8:0] data;
  } wr_t;

  wr_t        exp_q[$];
  wr_t        mon_exp;
  logic [8:0] model [16];
  int         passed = 0, total = 0;
  int         wr_cnt = 0, nack_cnt = 0, oen_cycles = 0;

  // Open-drain bus: the target can only pull SDA low.
  assign sda_bus = sda_m & ~sda_oen;

  always #5 clk = ~clk;

  i2c_reg_target #(.DEV_ADDR(7'h1A), .SYNC_STAGES(2)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_scl(scl_m), .i_sda(sda_bus),
    .o_sda_oen(sda_oen), .o_wr_valid(wr_valid), .o_wr_addr(wr_addr),
    .o_wr_data(wr_data), .i_rd_addr(rd_addr), .o_rd_data(rd_data),
    .o_busy(busy), .o_nack(nack)
  );

  // Monitor: counts pulses and checks each write against the scoreboard.
  always @(negedge clk) begin
    if (nack) nack_cnt++;
    if (sda_oen) oen_cycles++;
    if (wr_valid) begin
      wr_cnt++;
      total++;
      if (exp_q.size() == 0) begin
        $display("[TB] FAIL wr_unexpected: got addr=%h data=%h, required no write", wr_addr, wr_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (wr_addr !== mon_exp.addr || wr_data !== mon_exp.data)
          $display("[TB] FAIL wr_scoreboard: got addr=%h data=%h, required addr=%h data=%h",
                   wr_addr, wr_data, mon_exp.addr, mon_exp.data);
        else passed++;
      end
    end
  end

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // ---------------- bus master ----------------
  task automatic wait_q;
    repeat (4) @(negedge clk);
  endtask

  task automatic bus_start;
    sda_m = 1'b1; wait_q;
    scl_m = 1'b1; wait_q;
    sda_m = 1'b0; wait_q;
    scl_m = 1'b0; wait_q;
  endtask

  task automatic bus_stop;
    sda_m = 1'b0; wait_q;
    scl_m = 1'b1; wait_q;
    sda_m = 1'b1; wait_q;
  endtask

  task automatic bus_bit(input logic b);
    sda_m = b;    wait_q;
    scl_m = 1'b1; wait_q; wait_q;
    scl_m = 1'b0; wait_q;
  endtask

  task automatic bus_ack(output logic ack);
    sda_m = 1'b1; wait_q;
    scl_m = 1'b1; wait_q;
    ack = ~sda_bus; wait_q;
    scl_m = 1'b0; wait_q;
  endtask

  task automatic bus_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) bus_bit(b[i]);
    bus_ack(ack);
  endtask

  task automatic send_frame(input logic [7:0] b0, b1, b2, b3, input int n,
                            output logic [3:0] acks);
    logic [7:0] bytes [4];
    logic a;
    bytes[0] = b0; bytes[1] = b1; bytes[2] = b2; bytes[3] = b3;
    acks = '0;
    bus_start;
    for (int k = 0; k < n; k++) begin
      bus_byte(bytes[k], a);
      acks[k] = a;
    end
    bus_stop;
  endtask

  // Records the write a (byte1, byte2) pair should produce.
  task automatic expect_write(input logic [7:0] b1, b2);
    wr_t w;
    w.addr = b1[7:1];
    w.data = {b1[0], b2};
    exp_q.push_back(w);
    if (w.addr <= 7'h0E) model[w.addr[3:0]] = w.data;
    else if (w.addr == 7'h0F) for (int i = 0; i < 16; i++) model[i] = '0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    logic a;
    for (int i = 0; i < 16; i++) model[i] = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({sda_oen, wr_valid, nack, busy, wr_addr, wr_data} !== 20'h0)
      $display("[TB] FAIL reset_outputs: got %h, required 0",
               {sda_oen, wr_valid, nack, busy, wr_addr, wr_data});
    else passed++;
    for (int i = 0; i < 16; i++) begin
      rd_addr = i[3:0]; #1;
      total++;
      if (rd_data !== 9'h000) $display("[TB] FAIL reset_reg%0d: got %h, required 000", i, rd_data);
      else passed++;
    end
    rst_n = 1'b1;
    wait_q;
    // A byte without START must be ignored.
    scl_m = 1'b0; wait_q;
    bus_byte(8'h34, a);
    total++;
    if (a !== 1'b0 || busy !== 1'b0 || oen_cycles != 0)
      $display("[TB] FAIL no_start_ignored: got ack=%b busy=%b oen_cycles=%0d, required 0/0/0",
               a, busy, oen_cycles);
    else passed++;
    bus_stop;
  endtask

  task automatic test_basic_write;
    logic [3:0] acks;
    int w0 = wr_cnt;
    expect_write(8'h00, 8'h97);
    send_frame(8'h34, 8'h00, 8'h97, 8'h00, 3, acks);
    total++;
    if (acks[2:0] !== 3'b111) $display("[TB] FAIL basic_acks: got %b, required 111", acks[2:0]);
    else passed++;
    total++;
    if (wr_cnt - w0 != 1) $display("[TB] FAIL basic_wr_count: got %0d, required 1", wr_cnt - w0);
    else passed++;
    rd_addr = 4'd0; #1;
    total++;
    if (rd_data !== 9'h097) $display("[TB] FAIL basic_rd0: got %h, required 097", rd_data);
    else passed++;
  endtask

  task automatic test_write_and_clear;
    logic [3:0] acks;
    expect_write(8'h08, 8'h15);
    send_frame(8'h34, 8'h08, 8'h15, 8'h00, 3, acks);
    rd_addr = 4'd4; #1;
    total++;
    if (rd_data !== 9'h015) $display("[TB] FAIL entry4: got %h, required 015", rd_data);
    else passed++;
    expect_write(8'h1E, 8'h00);
    send_frame(8'h34, 8'h1E, 8'h00, 8'h00, 3, acks);
    total++;
    if (wr_addr !== 7'h0F) $display("[TB] FAIL clear_addr: got %h, required 0f", wr_addr);
    else passed++;
    for (int i = 0; i < 16; i++) begin
      rd_addr = i[3:0]; #1;
      total++;
      if (rd_data !== 9'h000) $display("[TB] FAIL clear_reg%0d: got %h, required 000", i, rd_data);
      else passed++;
    end
  endtask

  task automatic test_wrong_addr;
    logic [3:0] acks0, acks1, acks2;
    int n0, o0, w0;
    expect_write(8'h02, 8'h33);
    send_frame(8'h34, 8'h02, 8'h33, 8'h00, 3, acks0);
    n0 = nack_cnt; o0 = oen_cycles; w0 = wr_cnt;
    send_frame(8'h36, 8'h02, 8'h11, 8'h00, 3, acks1);
    send_frame(8'h35, 8'h02, 8'h11, 8'h00, 3, acks2);
    total++;
    if (acks1 !== 4'b0 || acks2 !== 4'b0)
      $display("[TB] FAIL wrong_addr_acks: got %b/%b, required 0000/0000", acks1, acks2);
    else passed++;
    total++;
    if (nack_cnt - n0 != 6) $display("[TB] FAIL wrong_addr_nacks: got %0d, required 6", nack_cnt - n0);
    else passed++;
    total++;
    if (oen_cycles != o0 || wr_cnt != w0)
      $display("[TB] FAIL wrong_addr_quiet: got oen_cycles+%0d writes+%0d, required 0/0",
               oen_cycles - o0, wr_cnt - w0);
    else passed++;
    for (int i = 0; i < 16; i++) begin
      rd_addr = i[3:0]; #1;
      total++;
      if (rd_data !== model[i]) $display("[TB] FAIL wrong_addr_reg%0d: got %h, required %h", i, rd_data, model[i]);
      else passed++;
    end
  endtask

  task automatic test_truncated_and_restart;
    logic a0, a1, a2, a3;
    int w0 = wr_cnt;
    bus_start;
    total++;
    if (busy !== 1'b1) $display("[TB] FAIL busy_after_start: got %b, required 1", busy);
    else passed++;
    bus_byte(8'h34, a0);
    bus_byte(8'h0A, a1);
    bus_stop;
    total++;
    if ({a0, a1} !== 2'b11 || busy !== 1'b0 || wr_cnt != w0)
      $display("[TB] FAIL truncated: got acks=%b busy=%b writes=%0d, required 11/0/0",
               {a0, a1}, busy, wr_cnt - w0);
    else passed++;
    // Repeated START in the middle of byte1.
    bus_start;
    bus_byte(8'h34, a0);
    bus_bit(1'b1); bus_bit(1'b0); bus_bit(1'b1);
    bus_start;
    expect_write(8'h06, 8'h42);
    bus_byte(8'h34, a0);
    bus_byte(8'h06, a1);
    bus_byte(8'h42, a2);
    bus_stop;
    a3 = 1'b1;
    total++;
    if ({a0, a1, a2, a3} !== 4'b1111 || wr_cnt - w0 != 1)
      $display("[TB] FAIL restart_frame: got acks=%b writes=%0d, required 111/1", {a0, a1, a2}, wr_cnt - w0);
    else passed++;
    rd_addr = 4'd3; #1;
    total++;
    if (rd_data !== 9'h042) $display("[TB] FAIL restart_entry3: got %h, required 042", rd_data);
    else passed++;
  endtask

  task automatic test_extra_byte;
    logic [3:0] acks;
    int n0 = nack_cnt;
    expect_write(8'h04, 8'h79);
    send_frame(8'h34, 8'h04, 8'h79, 8'h55, 4, acks);
    total++;
    if (acks !== 4'b0111 || nack_cnt - n0 != 1)
      $display("[TB] FAIL extra_byte: got acks=%b nacks=%0d, required 0111/1", acks, nack_cnt - n0);
    else passed++;
    rd_addr = 4'd2; #1;
    total++;
    if (rd_data !== 9'h079) $display("[TB] FAIL extra_entry2: got %h, required 079", rd_data);
    else passed++;
  endtask

  task automatic test_back_to_back;
    logic [3:0] acks;
    logic [6:0] ra;
    logic [8:0] d;
    int w0 = wr_cnt;
    for (int f = 0; f < 10; f++) begin
      ra = 7'($urandom_range(0, 19));
      d  = 9'($urandom_range(0, 511));
      expect_write({ra, d[8]}, d[7:0]);
      send_frame(8'h34, {ra, d[8]}, d[7:0], 8'h00, 3, acks);
      total++;
      if (acks[2:0] !== 3'b111) $display("[TB] FAIL b2b_acks%0d: got %b, required 111", f, acks[2:0]);
      else passed++;
    end
    total++;
    if (wr_cnt - w0 != 10) $display("[TB] FAIL b2b_writes: got %0d, required 10", wr_cnt - w0);
    else passed++;
    for (int i = 0; i < 16; i++) begin
      rd_addr = i[3:0]; #1;
      total++;
      if (rd_data !== model[i]) $display("[TB] FAIL b2b_reg%0d: got %h, required %h", i, rd_data, model[i]);
      else passed++;
    end
  endtask

  task automatic test_reset_midframe;
    logic a;
    int w0 = wr_cnt;
    // Reset pulse during byte2.
    bus_start;
    bus_byte(8'h34, a);
    bus_byte(8'h08, a);
    for (int i = 7; i >= 4; i--) bus_bit(1'b1);
    #3 rst_n = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || sda_oen !== 1'b0)
      $display("[TB] FAIL rst_byte2_async: got busy=%b oen=%b, required 0/0", busy, sda_oen);
    else passed++;
    for (int i = 0; i < 16; i++) model[i] = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 3; i >= 0; i--) bus_bit(1'b0);
    bus_ack(a);
    total++;
    if (a !== 1'b0) $display("[TB] FAIL rst_byte2_noack: got %b, required 0", a);
    else passed++;
    bus_stop;
    // Reset pulse while the target is driving the byte1 ACK.
    bus_start;
    bus_byte(8'h34, a);
    for (int i = 7; i >= 0; i--) bus_bit(i == 3);
    sda_m = 1'b1; wait_q;
    scl_m = 1'b1; wait_q;
    total++;
    if (sda_oen !== 1'b1) $display("[TB] FAIL ack1_driven: got %b, required 1", sda_oen);
    else passed++;
    #3 rst_n = 1'b0;
    #1;
    total++;
    if (sda_oen !== 1'b0) $display("[TB] FAIL rst_ack_release: got %b, required 0", sda_oen);
    else passed++;
    wait_q;
    scl_m = 1'b0; wait_q;
    rst_n = 1'b1; wait_q;
    bus_stop;
    total++;
    if (wr_cnt != w0) $display("[TB] FAIL rst_no_write: got %0d writes, required 0", wr_cnt - w0);
    else passed++;
    for (int i = 0; i < 16; i++) begin
      rd_addr = i[3:0]; #1;
      total++;
      if (rd_data !== 9'h000) $display("[TB] FAIL rst_reg%0d: got %h, required 000", i, rd_data);
      else passed++;
    end
  endtask

  initial begin
    test_reset;
    test_basic_write;
    test_write_and_clear;
    test_wrong_addr;
    test_truncated_and_restart;
    test_extra_byte;
    test_back_to_back;
    test_reset_midframe;
    repeat (4) @(negedge clk);
    total++;
    if (exp_q.size() != 0) $display("[TB] FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/i2c_reg_target.md
I2C_REG_TARGET -- requirements
Module: i2c_reg_target

Interface
REQ-001 Parameter DEV_ADDR, default 7'h1A, 7-bit I2C device address the block answers to.
REQ-002 Parameter SYNC_STAGES, default 2, number of synchronizer flops on the SCL and SDA inputs.
REQ-003 The block SHALL use one clock and an asynchronous active-low reset: i_clk is the clock and i_rst_n is the reset.
REQ-004 i_clk  input  1  system clock, at least 8x the SCL rate.
REQ-005 i_rst_n  input  1  asynchronous active-low reset.
REQ-006 i_scl  input  1  I2C clock from the bus master, asynchronous.
REQ-007 i_sda  input  1  I2C data line as seen on the bus, asynchronous.
REQ-008 o_sda_oen  output  1  1 = pull SDA low (ACK), 0 = release SDA.
REQ-009 o_wr_valid  output  1  one-cycle pulse on each accepted register write.
REQ-010 o_wr_addr  output  7  register address of the last accepted write.
REQ-011 o_wr_data  output  9  register data of the last accepted write.
REQ-012 i_rd_addr  input  4  register-file read index.
REQ-013 o_rd_data  output  9  combinational read of register i_rd_addr.
REQ-014 o_busy  output  1  high from START detect to STOP detect.
REQ-015 o_nack  output  1  one-cycle pulse when the block declines to ACK a byte.

Function
REQ-016 i_scl and i_sda SHALL pass through SYNC_STAGES flops; all edge and condition detection SHALL use the synchronized values only.
REQ-017 START (SDA falls while SCL is high) SHALL move the block from any state to ADDR, clear the bit count, and assert o_busy; a repeated START SHALL behave the same way.
REQ-018 STOP (SDA rises while SCL is high) SHALL move the block from any state to IDLE, release SDA, deassert o_busy, and discard any partial frame.
REQ-019 Data bits SHALL be sampled on the synchronized SCL rising edge, MSB first; 8 bits make one byte.
REQ-020 States: IDLE, ADDR, ACK_A, BYTE1, ACK_1, BYTE2, ACK_2, IGNORE.
REQ-021 On the SCL falling edge after the 8th ADDR bit: if byte[7:1]==DEV_ADDR and byte[0]==0, the block SHALL set o_sda_oen=1 and go to ACK_A; otherwise it SHALL pulse o_nack, keep SDA released, and go to IGNORE.
REQ-022 In ACK_x states, o_sda_oen SHALL stay 1 until the next SCL falling edge (end of the 9th clock), then drop to 0; ACK_A then goes to BYTE1 and ACK_1 goes to BYTE2.
REQ-023 BYTE1 SHALL latch reg_addr=byte[7:1] and d8=byte[0], then ACK it (ACK_1).
REQ-024 BYTE2 SHALL form data={d8,byte} and ACK it (ACK_2).
REQ-025 In the same i_clk cycle that o_sda_oen rises for ACK_2, the block SHALL pulse o_wr_valid and update o_wr_addr/o_wr_data.
REQ-026 If reg_addr<=7'h0E, the block SHALL write data into register file entry reg_addr[3:0], visible on o_rd_data the next cycle.
REQ-027 If reg_addr==7'h0F (reset register), the block SHALL clear all 16 entries to 9'h000 instead.
REQ-028 If reg_addr>=7'h10, the block SHALL still ACK and pulse o_wr_valid but SHALL leave the register file unchanged.
REQ-029 After ACK_2 the block SHALL go to IGNORE; every further byte SHALL be NACKed (o_nack pulse, SDA released) until STOP or START.
REQ-030 IGNORE SHALL never drive SDA.
REQ-031 Level changes of SDA while SCL is high, other than START/STOP, SHALL not occur in normal operation; any that do SHALL be treated as START/STOP per REQ-017/018.

Reset
REQ-032 While i_rst_n is low the block SHALL be in state IDLE, all register-file entries SHALL be 9'h000, o_sda_oen/o_wr_valid/o_nack/o_busy SHALL be 0, o_wr_addr SHALL be 0, o_wr_data SHALL be 0, and the synchronizer flops SHALL be 1.
REQ-033 Reset asserted mid-frame SHALL release SDA within the same cycle (asynchronously), and no write SHALL be committed.
REQ-034 After reset release, the block SHALL ignore bus activity until the first START detect.

Verification
REQ-035 START, 0x34, 0x00, 0x97, STOP -> ACK on all three 9th clocks, one o_wr_valid with addr 0x00 and data 0x097; i_rd_addr=0 -> o_rd_data=0x097.
REQ-036 START, 0x34, 0x08, 0x15, STOP -> addr 0x04, data 0x015, entry 4=0x015; START, 0x34, 0x1E, 0x00, STOP -> addr 0x0F, all entries read 0x000.
REQ-037 START, 0x36, ... and START, 0x35, ... -> o_nack pulse, SDA never driven, no o_wr_valid, register file unchanged.
REQ-038 START, 0x34, 0x0A, STOP (frame truncated) -> two ACKs, no write; then a repeated START inside a frame restarts at ADDR and the following full frame writes correctly.
REQ-039 START, 0x34, 0x04, 0x79, 0x55, STOP -> entry 2=0x079, fourth byte NACKed with an o_nack pulse.
REQ-040 Ten back-to-back frames generated by the team's I2C initializer -> ten o_wr_valid pulses, register file matching the written values; i_rst_n pulsed during byte 2 -> SDA released immediately, no write.
